// File: rtl/shf_arb_ctrl.sv
// -----------------------------------------------------------------------------
// shf_arb_ctrl
//
// Two-requester shift controller. A round-robin arbiter picks one requester
// while the controller is idle, captures that requester's operation, operand
// and shift amount, and then applies one single-bit shift step per clock until
// the requested amount has been consumed. The result is presented on r_o with
// a one-cycle done_o pulse tagged by done_id_o.
//
// Ports
//   clk          in   1     clock, rising edge
//   rst          in   1     asynchronous active-high reset
//   req0_i       in   1     requester 0 request, held until granted
//   req1_i       in   1     requester 1 request, held until granted
//   oper0_i      in   3     requester 0 shift operation
//   oper1_i      in   3     requester 1 shift operation
//   x0_i         in   N     requester 0 operand
//   x1_i         in   N     requester 1 operand
//   cnt0_i       in   M     requester 0 shift amount
//   cnt1_i       in   M     requester 1 shift amount
//   gnt0_o       out  1     one-cycle accept pulse to requester 0
//   gnt1_o       out  1     one-cycle accept pulse to requester 1
//   busy_o       out  1     transaction in progress (SHIFT or DONE)
//   done_o       out  1     one-cycle result-valid pulse
//   done_id_o    out  1     owner of the current result
//   r_o          out  N     result register
//
// Operation encoding (one step):
//   000 logical right, 001 arithmetic right, 010 rotate right,
//   011 / 100 logical left, 101 rotate left, 110 / 111 hold.
// -----------------------------------------------------------------------------
module shf_arb_ctrl #(
    parameter int N = 8,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [2:0]   oper0_i,
    input  logic [2:0]   oper1_i,
    input  logic [N-1:0] x0_i,
    input  logic [N-1:0] x1_i,
    input  logic [M-1:0] cnt0_i,
    input  logic [M-1:0] cnt1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         done_id_o,
    output logic [N-1:0] r_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [M-1:0] CNT_ZERO = M'(0);
    localparam logic [M-1:0] CNT_ONE  = M'(1);

    // One single-bit step of the selected operation; unknown codes hold data.
    function automatic logic [N-1:0] shift_step(input logic [2:0]   op,
                                                input logic [N-1:0] v);
        logic [N-1:0] res;
        res = v;
        case (op)
            3'b000:         res = {1'b0, v[N-1:1]};
            3'b001:         res = {v[N-1], v[N-1:1]};
            3'b010:         res = {v[0], v[N-1:1]};
            3'b011, 3'b100: res = {v[N-2:0], 1'b0};
            3'b101:         res = {v[N-2:0], v[N-1]};
            default:        res = v;
        endcase
        return res;
    endfunction

    // State and datapath registers
    state_t       state_q,     state_d;
    logic [2:0]   oper_q,      oper_d;
    logic         id_q,        id_d;
    logic [M-1:0] remaining_q, remaining_d;
    logic [N-1:0] data_q,      data_d;
    logic [N-1:0] r_q,         r_d;
    logic         last_id_q,   last_id_d;

    // Registered outputs
    logic         gnt0_q,      gnt0_d;
    logic         gnt1_q,      gnt1_d;
    logic         busy_q,      busy_d;
    logic         done_q,      done_d;
    logic         done_id_q,   done_id_d;

    // Arbitration and operand selection
    logic         any_req_s;
    logic         grant_id_s;
    logic [2:0]   sel_oper_s;
    logic [N-1:0] sel_x_s;
    logic [M-1:0] sel_cnt_s;
    logic [N-1:0] step_s;

    assign any_req_s = req0_i | req1_i;
    assign step_s    = shift_step(oper_q, data_q);

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_id_s = 1'b0;
        if (req0_i && req1_i) begin
            grant_id_s = ~last_id_q;
        end else if (req1_i) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Operand mux driven by the arbitration winner.
    always_comb begin
        sel_oper_s = oper0_i;
        sel_x_s    = x0_i;
        sel_cnt_s  = cnt0_i;
        if (grant_id_s) begin
            sel_oper_s = oper1_i;
            sel_x_s    = x1_i;
            sel_cnt_s  = cnt1_i;
        end else begin
            sel_oper_s = oper0_i;
            sel_x_s    = x0_i;
            sel_cnt_s  = cnt0_i;
        end
    end

    // Next-state and datapath logic of the controller FSM.
    always_comb begin
        state_d     = state_q;
        oper_d      = oper_q;
        id_d        = id_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        r_d         = r_q;
        last_id_d   = last_id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    id_d      = grant_id_s;
                    last_id_d = grant_id_s;
                    oper_d    = sel_oper_s;
                    gnt0_d    = ~grant_id_s;
                    gnt1_d    = grant_id_s;
                    data_d    = sel_x_s;
                    if (sel_cnt_s == CNT_ZERO) begin
                        // Zero-length shift: the operand is the result.
                        r_d         = sel_x_s;
                        remaining_d = CNT_ZERO;
                        state_d     = ST_DONE;
                    end else begin
                        remaining_d = sel_cnt_s;
                        state_d     = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d      = step_s;
                remaining_d = remaining_q - CNT_ONE;
                if (remaining_q == CNT_ONE) begin
                    // Last step: publish the shifted value directly.
                    r_d     = step_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so they line up with it.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        done_id_d = done_id_q;
        if (state_d == ST_DONE) begin
            done_id_d = id_d;
        end else begin
            done_id_d = done_id_q;
        end
    end

    // State register with asynchronous reset; last_id resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            oper_q      <= 3'b000;
            id_q        <= 1'b0;
            remaining_q <= CNT_ZERO;
            data_q      <= {N{1'b0}};
            r_q         <= {N{1'b0}};
            last_id_q   <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            oper_q      <= oper_d;
            id_q        <= id_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            r_q         <= r_d;
            last_id_q   <= last_id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign r_o       = r_q;

endmodule

// File: tb/tb_shf_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shf_arb_ctrl
//
// Directed bench for shf_arb_ctrl. Expected results are computed from a
// whole-amount shift model when each request is driven, queued, and compared
// when the controller pulses done. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shf_arb_ctrl;

    localparam int N = 8;
    localparam int M = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [2:0]   oper0, oper1;
    logic [N-1:0] x0, x1;
    logic [M-1:0] cnt0, cnt1;
    logic         gnt0, gnt1, busy, done, done_id;
    logic [N-1:0] r;

    typedef struct packed {
        logic         id;
        logic [N-1:0] r;
        logic [M-1:0] cnt;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic [N-1:0] last_r;
    int           n_chk  = 0;
    int           n_pass = 0;

    int   ndone, g0, g1, dbl, first_done, seen_done;
    logic pg0, pg1;

    shf_arb_ctrl #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (req0),
        .req1_i    (req1),
        .oper0_i   (oper0),
        .oper1_i   (oper1),
        .x0_i      (x0),
        .x1_i      (x1),
        .cnt0_i    (cnt0),
        .cnt1_i    (cnt1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .busy_o    (busy),
        .done_o    (done),
        .done_id_o (done_id),
        .r_o       (r)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Whole-amount reference: the composite effect of c single-bit steps.
    function automatic logic [N-1:0] model(input logic [2:0] op, input logic [N-1:0] x, input int c);
        logic [2*N-1:0] xx;
        xx = {x, x};
        case (op)
            3'b000:         return x >> c;
            3'b001:         return N'($signed(x) >>> c);
            3'b010:         begin xx = xx >> c; return xx[N-1:0]; end
            3'b011, 3'b100: return x << c;
            3'b101:         begin xx = xx << c; return xx[2*N-1:N]; end
            default:        return x;
        endcase
    endfunction

    // Drive one request from a falling edge with the controller idle and follow it to done.
    task automatic run_txn(input logic id, input logic [2:0] op, input logic [N-1:0] x,
                           input logic [M-1:0] c);
        exp_t ex;
        int   seen;
        if (id == 1'b0) begin
            req0 = 1'b1; oper0 = op; x0 = x; cnt0 = c;
        end else begin
            req1 = 1'b1; oper1 = op; x1 = x; cnt1 = c;
        end
        ex.id  = id;
        ex.r   = model(op, x, int'(c));
        ex.cnt = c;
        sb.push_back(ex);
        @(negedge clk);
        chk("gnt_own",   id ? gnt1 : gnt0, 32'd1);
        chk("gnt_other", id ? gnt0 : gnt1, 32'd0);
        chk("busy_e0",   busy, 32'd1);
        // Disturb every input; the accepted transaction must not notice.
        req0 = 1'b0; req1 = 1'b0;
        oper0 = ~op; oper1 = ~op; x0 = ~x; x1 = ~x; cnt0 = ~c; cnt1 = ~c;
        seen = 0;
        for (int k = 0; k <= int'(c) + 1 && seen == 0; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                seen = 1;
                if (sb.size() != 0) begin
                    ex = sb.pop_front();
                    chk("latency", k, 32'(ex.cnt));
                    chk("r",       r, 32'(ex.r));
                    chk("done_id", done_id, 32'(ex.id));
                    last_r = ex.r;
                end else begin
                    chk("sb_unexpected_done", done, 32'd0);
                end
            end else begin
                chk("r_hold", r, 32'(last_r));
                if (k > 0) begin
                    chk("gnt_pulse", gnt0 | gnt1, 32'd0);
                    chk("busy_shift", busy, 32'd1);
                end
            end
        end
        chk("done_seen", seen, 32'd1);
        @(negedge clk);
        chk("busy_idle", busy, 32'd0);
        chk("done_clear", done, 32'd0);
        chk("r_after", r, 32'(last_r));
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        oper0 = 3'b000; oper1 = 3'b000;
        x0 = 8'h00; x1 = 8'h00;
        cnt0 = 3'd0; cnt1 = 3'd0;
        last_r = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("rst_r",       r,       32'd0);
        chk("rst_done",    done,    32'd0);
        chk("rst_done_id", done_id, 32'd0);
        chk("rst_gnt0",    gnt0,    32'd0);
        chk("rst_gnt1",    gnt1,    32'd0);
        chk("rst_busy",    busy,    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Specified single-requester cases.
        run_txn(1'b0, 3'b001, 8'h96, 3'd3);   // r = F2
        run_txn(1'b1, 3'b101, 8'h96, 3'd4);   // r = 69
        run_txn(1'b0, 3'b000, 8'h96, 3'd0);   // r = 96
        run_txn(1'b0, 3'b110, 8'h5A, 3'd7);   // r = 5A
        // Remaining operation codes and boundary amounts.
        run_txn(1'b1, 3'b000, 8'hC3, 3'd7);
        run_txn(1'b0, 3'b010, 8'hB1, 3'd5);
        run_txn(1'b1, 3'b011, 8'hB1, 3'd1);
        run_txn(1'b0, 3'b100, 8'h81, 3'd2);
        run_txn(1'b1, 3'b111, 8'h3C, 3'd2);
        run_txn(1'b1, 3'b001, 8'h7F, 3'd6);

        // Both requesters held from reset: service order 0,1,0,1.
        rst = 1'b1;
        last_r = 8'h00;
        req0 = 1'b1; oper0 = 3'b001; x0 = 8'h81; cnt0 = 3'd1;
        req1 = 1'b1; oper1 = 3'b010; x1 = 8'h06; cnt1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            e.id  = i[0];
            e.r   = i[0] ? model(3'b010, 8'h06, 2) : model(3'b001, 8'h81, 1);
            e.cnt = i[0] ? 3'd2 : 3'd1;
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0; g0 = 0; g1 = 0; dbl = 0; first_done = -1; pg0 = 1'b0; pg1 = 1'b0;
        for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (gnt0) g0++;
            if (gnt1) g1++;
            if ((gnt0 && pg0) || (gnt1 && pg1)) dbl++;
            pg0 = gnt0;
            pg1 = gnt1;
            if (done) begin
                if (ndone == 0) first_done = cyc;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rr_done_id", done_id, 32'(e.id));
                    chk("rr_r",       r,       32'(e.r));
                    last_r = e.r;
                end else begin
                    chk("rr_unexpected_done", done, 32'd0);
                end
                ndone++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_done_count", ndone, 32'd4);
        chk("rr_gnt0_count", g0, 32'd2);
        chk("rr_gnt1_count", g1, 32'd2);
        chk("rr_gnt_single", dbl, 32'd0);
        chk("rr_first_done", first_done, 32'd2);
        @(negedge clk);

        // Reset during a cnt=5 transaction, asserted just after edge E0+2.
        req0 = 1'b1; oper0 = 3'b000; x0 = 8'hFF; cnt0 = 3'd5;
        @(posedge clk);
        req0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_r",       r,       32'd0);
        chk("mid_rst_done",    done,    32'd0);
        chk("mid_rst_done_id", done_id, 32'd0);
        chk("mid_rst_gnt0",    gnt0,    32'd0);
        chk("mid_rst_gnt1",    gnt1,    32'd0);
        chk("mid_rst_busy",    busy,    32'd0);
        last_r = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("abandoned_no_done", seen_done, 32'd0);
        run_txn(1'b0, 3'b001, 8'h96, 3'd3);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shf_arb_ctrl.md
SHF_ARB_CTRL -- requirements
Module: shf_arb_ctrl

Interface
REQ-001 Parameter N, default 8, data width.
REQ-002 Parameter M, default 3, shift-count width.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req0, req1  in  1 each  requester 0/1 shift request, held until granted.
REQ-006 oper0, oper1  in  3 each  shift operation of requester 0/1.
REQ-007 x0, x1  in  N each  operand of requester 0/1.
REQ-008 cnt0, cnt1  in  M each  shift amount of requester 0/1.
REQ-009 gnt0, gnt1  out  1 each  registered one-cycle accept pulse to requester 0/1.
REQ-010 busy  out  1  high while a transaction occupies the controller (states SHIFT, DONE).
REQ-011 done  out  1  one-cycle result-valid pulse.
REQ-012 done_id  out  1  owner of the current result (0 = requester 0, 1 = requester 1).
REQ-013 r  out  N  result register.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-015 In IDLE with any req high, the rising edge (E0) SHALL accept one requester and latch its oper, x and cnt plus id; gnt<id> SHALL be high for the cycle after E0 only.
REQ-016 Arbitration SHALL be round-robin: if only one req is high, grant it; if both are high, grant the requester not granted last; last_id SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 Requests SHALL be ignored outside IDLE; a req still high after its gnt pulse SHALL be treated as a new request once IDLE is re-entered.
REQ-018 At E0, if cnt==0, go to DONE with r<=x; otherwise go to SHIFT with remaining<=cnt and data<=x.
REQ-019 Each edge in SHIFT SHALL apply one 1-bit step to data and decrement remaining; on the edge where remaining==1, go to DONE and load r with the shifted value.
REQ-020 Result latency: done SHALL be high in the cycle following edge E0+cnt (cnt 0..2^M-1).
REQ-021 Step per oper: 000 logical right (0 in), 001 arithmetic right (MSB kept), 010 rotate right, 011 logical left, 100 arithmetic left (same as 011), 101 rotate left.
REQ-022 For oper 110/111, data SHALL be held unchanged for every step; timing SHALL be unchanged and the request SHALL still complete with done.
REQ-023 In DONE, done SHALL be 1 and done_id SHALL equal the owner id; the next edge SHALL go to IDLE.
REQ-024 r SHALL change only on the edge entering DONE and SHALL hold its value until the next such edge.
REQ-025 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.
REQ-026 Input changes after E0 SHALL NOT affect the transaction in flight.
REQ-027 Earliest next acceptance SHALL be edge E0+cnt+2, giving a throughput of one request per cnt+2 cycles.

Reset
REQ-028 rst high SHALL immediately force state=IDLE, r=0, done=0, done_id=0, gnt0=gnt1=0, busy=0, remaining=0, data=0, last_id=1.
REQ-029 Reset asserted mid-transaction SHALL abandon it; no done SHALL be produced for it.
REQ-030 After rst deasserts, the first rising edge with req high SHALL be a valid E0.

Verification
REQ-031 req0, oper0=001, x0=8'h96, cnt0=3 -> gnt0 one cycle after E0; done=1 with r=8'hF2 and done_id=0 after edge E0+3; busy low again after E0+4.
REQ-032 req1, oper1=101, x1=8'h96, cnt1=4 -> r=8'h69, done_id=1 after edge E0+4; gnt0 never asserted.
REQ-033 req0, oper0=000, x0=8'h96, cnt0=0 -> done with r=8'h96 after E0 itself.
REQ-034 req0 and req1 both held high from reset -> served order 0,1,0,1; each gnt is a single cycle; r values match each owner's operands.
REQ-035 rst pulsed at E0+2 during cnt=5 -> all outputs 0 at once; no done; the next request completes normally.
REQ-036 oper=110, x=8'h5A, cnt=7 -> r=8'h5A, done after edge E0+7.
